// File: rtl/delay_arbiter.sv
// Round-robin arbiter handing one shared delay counter to four requesters; owner is granted, counts to its
// latched terminal value, then pulses done. All outputs registered; a dropped owner request aborts the run.
module delay_arbiter #(
  parameter int COUNTER_WIDTH = 10,
  parameter int NUM_REQ       = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_REQ-1:0]               req,
  input  logic [NUM_REQ*COUNTER_WIDTH-1:0] max_in,
  output logic [NUM_REQ-1:0]               grant,
  output logic [NUM_REQ-1:0]               done,
  output logic                             busy,
  output logic [1:0]                       active_id
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t                   state_q, state_d;
  logic [COUNTER_WIDTH-1:0] cnt_q, cnt_d;
  logic [COUNTER_WIDTH-1:0] max_q, max_d;
  logic [1:0]               last_q, last_d;
  logic [1:0]               active_q, active_d;
  logic [NUM_REQ-1:0]       grant_q, grant_d;
  logic [NUM_REQ-1:0]       done_q, done_d;
  logic                     busy_q, busy_d;

  logic                     win_found;
  logic [1:0]               win_id;
  logic [1:0]               cand;
  logic [COUNTER_WIDTH-1:0] win_max;
  logic [NUM_REQ-1:0]       act_oh;

  // Search starts one past the last owner and wraps, so the previous owner has lowest priority.
  always_comb begin
    win_found = 1'b0;
    win_id    = last_q;
    cand      = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = last_q + 2'(k);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_id    = cand;
      end
    end
    win_max = max_in[win_id*COUNTER_WIDTH +: COUNTER_WIDTH];
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    max_d    = max_q;
    last_d   = last_q;
    active_d = active_q;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (win_found) begin
          state_d  = ST_RUN;
          max_d    = win_max;
          last_d   = win_id;
          active_d = win_id;
        end
      end
      ST_RUN: begin
        // Abort has precedence over reaching the terminal count.
        if (!req[active_q]) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == max_q) begin
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + COUNTER_WIDTH'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d  = ST_IDLE;
        cnt_d    = '0;
        active_d = '0;
      end
    endcase
  end

  // Outputs are derived from the next state so that they can be registered without a cycle of lag.
  always_comb begin
    act_oh           = '0;
    act_oh[active_d] = 1'b1;
    grant_d          = (state_d == ST_RUN)  ? act_oh : '0;
    done_d           = (state_d == ST_DONE) ? act_oh : '0;
    busy_d           = (state_d == ST_RUN) || (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      max_q    <= '0;
      last_q   <= 2'd3;
      active_q <= '0;
      grant_q  <= '0;
      done_q   <= '0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      max_q    <= max_d;
      last_q   <= last_d;
      active_q <= active_d;
      grant_q  <= grant_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  assign grant     = grant_q;
  assign done      = done_q;
  assign busy      = busy_q;
  assign active_id = active_q;

endmodule

// File: tb/tb_delay_arbiter.sv
// Bench for delay_arbiter: directed scenarios plus randomized traffic checked cycle by cycle against
// a transaction-level round-robin model.
module tb_delay_arbiter;
  localparam int CW = 10;

  logic            clk = 1'b0;
  logic            rst;
  logic [3:0]      req;
  logic [4*CW-1:0] max_in;
  logic [3:0]      grant;
  logic [3:0]      done;
  logic            busy;
  logic [1:0]      active_id;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int model_last = 3;

  always #5 clk = ~clk;

  delay_arbiter #(.COUNTER_WIDTH(CW), .NUM_REQ(4)) dut (
    .clk(clk), .rst(rst), .req(req), .max_in(max_in),
    .grant(grant), .done(done), .busy(busy), .active_id(active_id)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, cycles=%0d required=finish", cyc);
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic set_max(input int id, input int v);
    max_in[id*CW +: CW] = CW'(v);
  endtask

  function automatic int rr_pick(input logic [3:0] r, input int last);
    for (int k = 1; k <= 4; k++) begin
      if (r[(last + k) % 4]) return (last + k) % 4;
    end
    return -1;
  endfunction

  // One full transaction from the IDLE cycle: grant, run, then done or abort.
  task automatic do_txn(input string name, input int abort_at, input bit perturb);
    logic [10:0] obs, exp;
    logic [3:0]  oh;
    int          w, mx;
    w = rr_pick(req, model_last);
    if (w < 0) begin
      checks++; failures++;
      $display("FAIL %s no_request: req=%b required=nonzero", name, req);
      return;
    end
    mx = int'(max_in[w*CW +: CW]);
    oh = 4'b0001 << w;
    tick;
    model_last = w;
    exp = {oh, 4'b0000, 1'b1, 2'(w)};
    for (int c = 0; c <= mx; c++) begin
      if (c > 0) tick;
      obs = {grant, done, busy, active_id};
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL %s run c=%0d: {grant,done,busy,id}=%b required=%b", name, c, obs, exp);
      end
      if (perturb) begin
        req = 4'($urandom) | oh;
        for (int i = 0; i < 4; i++) set_max(i, int'($urandom));
      end
      if (c == abort_at) begin
        req[w] = 1'b0;
        tick;
        obs = {grant, done, busy, active_id};
        exp = {4'b0000, 4'b0000, 1'b0, 2'(w)};
        checks++;
        if (obs !== exp) begin
          failures++;
          $display("FAIL %s abort: {grant,done,busy,id}=%b required=%b", name, obs, exp);
        end
        return;
      end
    end
    tick;
    obs = {grant, done, busy, active_id};
    exp = {4'b0000, oh, 1'b1, 2'(w)};
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s done: {grant,done,busy,id}=%b required=%b", name, obs, exp);
    end
    req[w] = 1'b0;
    tick;
    obs = {grant, done, busy, active_id};
    exp = {4'b0000, 4'b0000, 1'b0, 2'(w)};
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s idle: {grant,done,busy,id}=%b required=%b", name, obs, exp);
    end
  endtask

  task automatic settle;
    req = 4'b0000;
    tick;
    tick;
  endtask

  task automatic test_reset;
    logic [10:0] obs;
    rst = 1'b0;
    req = 4'b1111;
    for (int i = 0; i < 4; i++) set_max(i, 3);
    tick;
    tick;
    obs = {grant, done, busy, active_id};
    checks++;
    if (obs !== 11'b0) begin
      failures++;
      $display("FAIL reset_hold: {grant,done,busy,id}=%b required=%b", obs, 11'b0);
    end
    req = 4'b0000;
    rst = 1'b1;
    model_last = 3;
    tick;
    obs = {grant, done, busy, active_id};
    checks++;
    if (obs !== 11'b0) begin
      failures++;
      $display("FAIL reset_release: {grant,done,busy,id}=%b required=%b", obs, 11'b0);
    end
  endtask

  task automatic test_single;
    req = 4'b0100;
    set_max(2, 5);
    do_txn("single", -1, 1'b0);
    settle();
  endtask

  task automatic test_zero_delay;
    req = 4'b0001;
    set_max(0, 0);
    do_txn("zero_delay", -1, 1'b0);
    settle();
  endtask

  task automatic test_max_change;
    logic [10:0] obs;
    req = 4'b0001;
    set_max(0, 4);
    tick;
    model_last = 0;
    set_max(0, 1023);
    for (int c = 0; c <= 4; c++) begin
      if (c > 0) tick;
      obs = {grant, done, busy, active_id};
      checks++;
      if (obs !== {4'b0001, 4'b0000, 1'b1, 2'd0}) begin
        failures++;
        $display("FAIL max_change run c=%0d: {grant,done,busy,id}=%b required=%b", c, obs, {4'b0001, 4'b0000, 1'b1, 2'd0});
      end
    end
    tick;
    obs = {grant, done, busy, active_id};
    checks++;
    if (obs !== {4'b0000, 4'b0001, 1'b1, 2'd0}) begin
      failures++;
      $display("FAIL max_change done: {grant,done,busy,id}=%b required=%b", obs, {4'b0000, 4'b0001, 1'b1, 2'd0});
    end
    settle();
  endtask

  task automatic test_abort;
    req = 4'b0010;
    set_max(1, 10);
    do_txn("abort", 3, 1'b0);
    req = 4'b0110;
    set_max(2, 3);
    do_txn("abort_next", -1, 1'b0);
    settle();
  endtask

  task automatic test_fairness;
    test_reset();
    req = 4'b1111;
    for (int i = 0; i < 4; i++) set_max(i, 2);
    for (int i = 0; i < 4; i++) do_txn("fairness", -1, 1'b0);
    settle();
  endtask

  task automatic test_reset_mid_run;
    logic [10:0] obs;
    req = 4'b0100;
    set_max(2, 8);
    tick;
    model_last = 2;
    obs = {grant, done, busy, active_id};
    checks++;
    if (obs !== {4'b0100, 4'b0000, 1'b1, 2'd2}) begin
      failures++;
      $display("FAIL rst_mid grant: {grant,done,busy,id}=%b required=%b", obs, {4'b0100, 4'b0000, 1'b1, 2'd2});
    end
    tick;
    tick;
    rst = 1'b0;
    tick;
    obs = {grant, done, busy, active_id};
    checks++;
    if (obs !== 11'b0) begin
      failures++;
      $display("FAIL rst_mid cleared: {grant,done,busy,id}=%b required=%b", obs, 11'b0);
    end
    rst = 1'b1;
    model_last = 3;
    req = 4'b1001;
    for (int i = 0; i < 4; i++) set_max(i, 5);
    do_txn("rst_mid_after", -1, 1'b0);
    settle();
  endtask

  task automatic test_random;
    int ab;
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 1) == 1 || req == 4'b0000) req = 4'($urandom_range(1, 15));
      for (int i = 0; i < 4; i++) set_max(i, int'($urandom_range(0, 12)));
      ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 12)) : -1;
      do_txn("random", ab, 1'b1);
    end
    settle();
  endtask

  initial begin
    rst = 1'b0;
    req = 4'b0000;
    max_in = '0;
    test_reset();
    test_single();
    test_zero_delay();
    test_max_change();
    test_abort();
    test_fairness();
    test_reset_mid_run();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
